// File: rtl/cprv_pkg.sv
// Shared constants and types for the cprv instruction-fetch front end.
package cprv_pkg;

  localparam int INSTR_BYTES = 4;
  localparam int DEFAULT_ADDR_WIDTH = 64;
  localparam int DEFAULT_INSTR_WIDTH = 32;
  localparam logic [63:0] DEFAULT_RESET_PC = 64'h0000_0000_8000_0000;

  typedef struct packed {
    logic [DEFAULT_ADDR_WIDTH-1:0]  pc;
    logic [DEFAULT_INSTR_WIDTH-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/cprv_fetch_unit_if.sv
// Fetch-unit bus: redirect input, imem request/response channels and the ID-side queue head.
interface cprv_fetch_unit_if #(
  parameter int ADDR_WIDTH  = 64,
  parameter int INSTR_WIDTH = 32,
  parameter int FIFO_DEPTH  = 4
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic                   redirect_valid_i;
  logic [ADDR_WIDTH-1:0]  redirect_pc_i;
  logic                   valid_imem_o;
  logic                   ready_imem_i;
  logic [ADDR_WIDTH-1:0]  instr_addr_imem_o;
  logic                   valid_if_i;
  logic                   ready_if_o;
  logic [INSTR_WIDTH-1:0] instr_data_imem_i;
  logic                   valid_id_o;
  logic                   ready_id_i;
  logic [INSTR_WIDTH-1:0] instr_data_id_o;
  logic [ADDR_WIDTH-1:0]  pc_id_o;
  logic [CNT_W-1:0]       fifo_count_o;

  modport master (
    input  redirect_valid_i, redirect_pc_i, ready_imem_i, valid_if_i,
           instr_data_imem_i, ready_id_i,
    output valid_imem_o, instr_addr_imem_o, ready_if_o, valid_id_o,
           instr_data_id_o, pc_id_o, fifo_count_o
  );

  modport slave (
    output redirect_valid_i, redirect_pc_i, ready_imem_i, valid_if_i,
           instr_data_imem_i, ready_id_i,
    input  valid_imem_o, instr_addr_imem_o, ready_if_o, valid_id_o,
           instr_data_id_o, pc_id_o, fifo_count_o
  );

endinterface

// File: rtl/cprv_sync_fifo.sv
// Synchronous FIFO with registered head data/valid, flush, and same-cycle push+pop.
module cprv_sync_fifo #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       valid,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    rd_ptr_r, wr_ptr_r, rd_next_s;
  logic [CW-1:0]    count_r, count_next_s;
  logic [WIDTH-1:0] dout_r, dout_next_s;
  logic             valid_r, push_ok_s, pop_ok_s;

  // Next pointers, occupancy and the entry that becomes the head next cycle.
  always_comb begin
    pop_ok_s     = pop && valid_r;
    push_ok_s    = push && ((count_r != FULL) || pop_ok_s);
    rd_next_s    = rd_ptr_r + PW'(pop_ok_s);
    count_next_s = count_r + CW'(push_ok_s) - CW'(pop_ok_s);
    if (count_next_s == CW'(0)) begin
      dout_next_s = dout_r;
    end else if (push_ok_s && ((count_r - CW'(pop_ok_s)) == CW'(0))) begin
      // Queue drains to empty this cycle, so the incoming word becomes the head.
      dout_next_s = din;
    end else begin
      dout_next_s = mem_r[rd_next_s];
    end
  end

  // Storage, pointers and registered head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
      rd_ptr_r <= PW'(0);
      wr_ptr_r <= PW'(0);
      count_r  <= CW'(0);
      valid_r  <= 1'b0;
      dout_r   <= {WIDTH{1'b0}};
    end else if (flush) begin
      rd_ptr_r <= PW'(0);
      wr_ptr_r <= PW'(0);
      count_r  <= CW'(0);
      valid_r  <= 1'b0;
      dout_r   <= {WIDTH{1'b0}};
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= wr_ptr_r + PW'(1);
      end
      rd_ptr_r <= rd_next_s;
      count_r  <= count_next_s;
      valid_r  <= (count_next_s != CW'(0));
      dout_r   <= dout_next_s;
    end
  end

  assign dout  = dout_r;
  assign valid = valid_r;
  assign count = count_r;

endmodule

// File: rtl/cprv_fetch_unit.sv
// IF stage: PC ownership, credit-limited imem requests, stale-response discard and prefetch queue.
module cprv_fetch_unit
  import cprv_pkg::*;
#(
  parameter int                    ADDR_WIDTH      = 64,
  parameter int                    INSTR_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC        = ADDR_WIDTH'(DEFAULT_RESET_PC),
  parameter int                    FIFO_DEPTH      = 4,
  parameter int                    MAX_OUTSTANDING = 2
) (
  input logic               clk,
  input logic               rst_n,
  cprv_fetch_unit_if.master bus
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = $clog2(MAX_OUTSTANDING + FIFO_DEPTH + 1);
  localparam logic [OW-1:0]         MAX_OUT = OW'(MAX_OUTSTANDING);
  localparam logic [SW-1:0]         DEPTH_S = SW'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(INSTR_BYTES);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]  pc;
    logic [INSTR_WIDTH-1:0] instr;
  } entry_t;

  logic [ADDR_WIDTH-1:0] fetch_pc_r, resp_pc_r, redirect_pc_s;
  logic [OW-1:0]         outstanding_r, outstanding_next_s;
  logic [OW-1:0]         discard_cnt_r, discard_next_s;
  logic [CW-1:0]         fifo_count_s, count_next_s;
  logic [SW-1:0]         credit_use_s;
  logic                  valid_imem_r, ready_if_r, valid_next_s;
  logic                  req_fire_s, rsp_fire_s, push_s, pop_s, head_valid_s;
  logic                  unused_pc_bits_s;
  entry_t                push_data_s, head_s;

  assign unused_pc_bits_s = ^bus.redirect_pc_i[1:0];

  // Handshakes, discard bookkeeping and the credit check for next cycle's request.
  always_comb begin
    req_fire_s         = valid_imem_r & bus.ready_imem_i;
    rsp_fire_s         = bus.valid_if_i & ready_if_r;
    redirect_pc_s      = {bus.redirect_pc_i[ADDR_WIDTH-1:2], 2'b00};
    outstanding_next_s = outstanding_r + OW'(req_fire_s) - OW'(rsp_fire_s);
    push_data_s        = '{pc: resp_pc_r, instr: bus.instr_data_imem_i};
    if (bus.redirect_valid_i) begin
      // Everything still in flight, including a request accepted now, is stale.
      push_s         = 1'b0;
      pop_s          = 1'b0;
      discard_next_s = outstanding_next_s;
      count_next_s   = CW'(0);
    end else begin
      push_s         = rsp_fire_s && (discard_cnt_r == OW'(0));
      pop_s          = head_valid_s && bus.ready_id_i;
      discard_next_s = (rsp_fire_s && !push_s) ? discard_cnt_r - OW'(1) : discard_cnt_r;
      count_next_s   = fifo_count_s + CW'(push_s) - CW'(pop_s);
    end
    credit_use_s = SW'(outstanding_next_s) + SW'(count_next_s);
    valid_next_s = (outstanding_next_s < MAX_OUT) && (credit_use_s < DEPTH_S);
  end

  // PCs, credit counters and registered channel controls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_r    <= RESET_PC;
      resp_pc_r     <= RESET_PC;
      outstanding_r <= OW'(0);
      discard_cnt_r <= OW'(0);
      valid_imem_r  <= 1'b0;
      ready_if_r    <= 1'b0;
    end else begin
      outstanding_r <= outstanding_next_s;
      discard_cnt_r <= discard_next_s;
      valid_imem_r  <= valid_next_s;
      ready_if_r    <= 1'b1;
      if (bus.redirect_valid_i) begin
        fetch_pc_r <= redirect_pc_s;
        resp_pc_r  <= redirect_pc_s;
      end else begin
        if (req_fire_s) begin
          fetch_pc_r <= fetch_pc_r + PC_STEP;
        end
        if (push_s) begin
          resp_pc_r <= resp_pc_r + PC_STEP;
        end
      end
    end
  end

  cprv_sync_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .pop   (pop_s),
    .flush (bus.redirect_valid_i),
    .din   (push_data_s),
    .dout  (head_s),
    .valid (head_valid_s),
    .count (fifo_count_s)
  );

  assign bus.valid_imem_o      = valid_imem_r;
  assign bus.instr_addr_imem_o = fetch_pc_r;
  assign bus.ready_if_o        = ready_if_r;
  assign bus.valid_id_o        = head_valid_s;
  assign bus.instr_data_id_o   = head_s.instr;
  assign bus.pc_id_o           = head_s.pc;
  assign bus.fifo_count_o      = fifo_count_s;

endmodule

// File: tb/tb_cprv_fetch_unit.sv
// Self-checking bench: epoch-tagged imem model plus expected-instruction queue for cprv_fetch_unit.
module tb_cprv_fetch_unit;

  localparam int          DEPTH = 4;
  localparam int          MAXO  = 2;
  localparam logic [63:0] RPC   = 64'h0000_0000_8000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cprv_fetch_unit_if bus ();
  cprv_fetch_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct { logic [63:0] addr; int epoch; int due; } req_t;
  typedef struct {
    bit rdy_imem; bit rdy_id; bit exp_vimem; logic [63:0] exp_addr; bit exp_vid; logic [63:0] exp_pc;
  } vec_t;

  req_t        imq[$];   // requests accepted by imem, oldest first
  logic [63:0] mq[$];    // PCs that ID should see, in order
  logic [63:0] next_addr;
  int          epoch, cyc;
  int          total = 0, bad = 0, nprint = 0;
  int          p_rimem, p_rid, p_rsp, p_redir, lat_lo, lat_hi;
  bit          force_redir = 1'b0;
  logic [63:0] force_tgt;
  bit          last_rsp_fire, last_pop;
  vec_t        tbl[5];

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (nprint < 40) begin
        nprint++;
        $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
      end
    end
  endfunction

  function automatic logic [63:0] rand_target();
    logic [63:0] t;
    case ($urandom_range(3, 0))
      0: t = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(15, 0));
      1: t = {32'd0, $urandom};
      default: t = {$urandom, $urandom};
    endcase
    return t;
  endfunction

  task automatic set_mode(input int ri, input int rid, input int rsp, input int rdr, input int lo, input int hi);
    p_rimem = ri; p_rid = rid; p_rsp = rsp; p_redir = rdr; lat_lo = lo; lat_hi = hi;
  endtask

  task automatic idle_inputs();
    bus.redirect_valid_i  = 1'b0;
    bus.redirect_pc_i     = 64'd0;
    bus.ready_imem_i      = 1'b0;
    bus.valid_if_i        = 1'b0;
    bus.instr_data_imem_i = 32'd0;
    bus.ready_id_i        = 1'b0;
  endtask

  // One cycle: check outputs against the model, drive inputs, advance the model, go to next negedge.
  task automatic step();
    bit          rf, sf, pf, rd;
    logic [63:0] tgt, dmy;
    req_t        e;
    chk("req_valid", 64'(bus.valid_imem_o), 64'((imq.size() < MAXO) && (imq.size() + mq.size() < DEPTH)));
    chk("req_addr", bus.instr_addr_imem_o, next_addr);
    chk("rsp_ready", 64'(bus.ready_if_o), 64'd1);
    chk("fifo_count", 64'(bus.fifo_count_o), 64'(mq.size()));
    chk("id_valid", 64'(bus.valid_id_o), 64'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk("id_pc", bus.pc_id_o, mq[0]);
      chk("id_instr", 64'(bus.instr_data_id_o), {32'd0, mq[0][31:0]});
    end
    bus.ready_imem_i = ($urandom_range(99, 0) < p_rimem);
    if (imq.size() != 0 && imq[0].due <= cyc && $urandom_range(99, 0) < p_rsp) begin
      bus.valid_if_i        = 1'b1;
      bus.instr_data_imem_i = imq[0].addr[31:0];
    end else begin
      bus.valid_if_i        = 1'b0;
      bus.instr_data_imem_i = $urandom;
    end
    bus.ready_id_i = ($urandom_range(99, 0) < p_rid);
    rd  = force_redir || ($urandom_range(99, 0) < p_redir);
    tgt = force_redir ? force_tgt : rand_target();
    force_redir = 1'b0;
    bus.redirect_valid_i = rd;
    bus.redirect_pc_i    = tgt;
    rf = bus.valid_imem_o & bus.ready_imem_i;
    sf = bus.valid_if_i & bus.ready_if_o;
    pf = bus.valid_id_o & bus.ready_id_i;
    last_rsp_fire = sf;
    last_pop      = pf;
    if (sf) begin
      e = imq.pop_front();
      if (!rd && e.epoch == epoch) mq.push_back(e.addr);
    end
    if (pf && !rd && mq.size() != 0) dmy = mq.pop_front();
    if (rf) begin
      imq.push_back('{next_addr, epoch, cyc + int'($urandom_range(lat_hi, lat_lo))});
      next_addr = next_addr + 64'd4;
    end
    if (rd) begin
      mq.delete();
      epoch++;
      next_addr = {tgt[63:2], 2'b00};
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    imq.delete();
    mq.delete();
    next_addr = RPC;
    epoch     = 0;
    repeat (2) @(negedge clk);
    chk("rst_valid_imem", 64'(bus.valid_imem_o), 64'd0);
    chk("rst_addr", bus.instr_addr_imem_o, RPC);
    chk("rst_ready_if", 64'(bus.ready_if_o), 64'd0);
    chk("rst_valid_id", 64'(bus.valid_id_o), 64'd0);
    chk("rst_instr_id", 64'(bus.instr_data_id_o), 64'd0);
    chk("rst_pc_id", bus.pc_id_o, 64'd0);
    chk("rst_count", 64'(bus.fifo_count_o), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    cyc = 1;
  endtask

  task automatic run_table();
    set_mode(100, 100, 100, 0, 1, 1);
    for (int i = 0; i < 5; i++) begin
      p_rimem = tbl[i].rdy_imem ? 100 : 0;
      p_rid   = tbl[i].rdy_id ? 100 : 0;
      chk("tbl_valid_imem", 64'(bus.valid_imem_o), 64'(tbl[i].exp_vimem));
      chk("tbl_addr", bus.instr_addr_imem_o, tbl[i].exp_addr);
      chk("tbl_valid_id", 64'(bus.valid_id_o), 64'(tbl[i].exp_vid));
      if (tbl[i].exp_vid) begin
        chk("tbl_pc", bus.pc_id_o, tbl[i].exp_pc);
        chk("tbl_instr", 64'(bus.instr_data_id_o), {32'd0, tbl[i].exp_pc[31:0]});
      end
      step();
    end
  endtask

  initial begin
    logic [63:0] a0;
    tbl[0] = '{1'b1, 1'b1, 1'b1, 64'h8000_0000, 1'b0, 64'd0};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 64'h8000_0004, 1'b0, 64'd0};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 64'h8000_0008, 1'b1, 64'h8000_0000};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 64'h8000_000C, 1'b1, 64'h8000_0004};
    tbl[4] = '{1'b1, 1'b1, 1'b1, 64'h8000_0010, 1'b1, 64'h8000_0008};
    cyc = 0;
    idle_inputs();

    // Reset release and back-to-back stream.
    do_reset();
    run_table();

    // ID stall: queue fills to DEPTH and requests stop, then drains in order.
    set_mode(100, 0, 100, 0, 1, 1);
    repeat (20) step();
    chk("t2_count_full", 64'(bus.fifo_count_o), 64'd4);
    chk("t2_req_blocked", 64'(bus.valid_imem_o), 64'd0);
    p_rid = 100;
    repeat (10) step();

    // Redirect with two requests in flight.
    do_reset();
    set_mode(100, 100, 100, 0, 3, 3);
    for (int i = 0; i < 20 && imq.size() != 2; i++) step();
    chk("t3_two_outstanding", 64'(imq.size()), 64'd2);
    force_redir = 1'b1;
    force_tgt   = 64'h8000_1000;
    step();
    chk("t3_redirect_addr", bus.instr_addr_imem_o, 64'h8000_1000);
    for (int i = 0; i < 40 && !bus.valid_id_o; i++) step();
    chk("t3_first_valid", 64'(bus.valid_id_o), 64'd1);
    chk("t3_first_pc", bus.pc_id_o, 64'h8000_1000);

    // Redirect colliding with a response and an ID pop.
    set_mode(100, 100, 100, 0, 1, 1);
    for (int i = 0; i < 30 && !(bus.valid_id_o && imq.size() != 0 && imq[0].due <= cyc); i++) step();
    force_redir = 1'b1;
    force_tgt   = 64'h8000_2003;
    step();
    chk("t4_collision", {62'd0, last_rsp_fire, last_pop}, 64'd3);
    chk("t4_count_flushed", 64'(bus.fifo_count_o), 64'd0);
    chk("t4_valid_flushed", 64'(bus.valid_id_o), 64'd0);
    for (int i = 0; i < 40 && !bus.valid_id_o; i++) step();
    chk("t4_first_pc", bus.pc_id_o, 64'h8000_2000);

    // Request held while imem is not ready.
    a0 = next_addr;
    chk("t5_valid_start", 64'(bus.valid_imem_o), 64'd1);
    set_mode(0, 100, 100, 0, 1, 1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t5_hold_valid", 64'(bus.valid_imem_o), 64'd1);
      chk("t5_hold_addr", bus.instr_addr_imem_o, a0);
    end
    p_rimem = 100;
    step();
    chk("t5_advance", bus.instr_addr_imem_o, a0 + 64'd4);

    // Asynchronous reset with entries queued.
    set_mode(100, 0, 100, 0, 1, 1);
    for (int i = 0; i < 30 && bus.fifo_count_o != 3'd3; i++) step();
    chk("t6_three_queued", 64'(bus.fifo_count_o), 64'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_valid_id", 64'(bus.valid_id_o), 64'd0);
    chk("t6_async_valid_imem", 64'(bus.valid_imem_o), 64'd0);
    chk("t6_async_count", 64'(bus.fifo_count_o), 64'd0);
    do_reset();
    run_table();

    // Randomised traffic with redirects, including targets near address wrap.
    do_reset();
    for (int blk = 0; blk < 15; blk++) begin
      set_mode(int'($urandom_range(100, 30)), int'($urandom_range(100, 20)),
               int'($urandom_range(100, 50)), int'($urandom_range(6, 0)), 1,
               int'($urandom_range(5, 1)));
      repeat (200) step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
